bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised sequential binary-to-BCD converter: the next generation of the team's divide-by-ten digit converter, built for the display and telemetry paths of the power-quality datapath. It converts a BIN_W-bit unsigned or two's-complement word into DIGITS packed BCD digits using iterative shift-and-add-3 (double dabble), one input bit per clock. It adds sign handling, an overflow flag and a leading-zero blanking mask, and uses a start/busy/done handshake with results held until the next conversion.

## Interface
- BIN_W, 16, input word width; legal range 4..32
- DIGITS, 5, number of output BCD digits; legal range 1..10
- SIGNED, 0, 1 = din is two's complement, 0 = din is unsigned
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset: one clock; reset is asynchronous and active-high
- start  input  1  conversion request; sampled only in IDLE
- din  input  BIN_W  value to convert; sampled on the accepting edge only
- busy  output  1  high from the accepting edge until the result edge
- done  output  1  one-cycle pulse: the result outputs were just updated
- bcd  output  4*DIGITS  packed BCD; digit i at bits [4i+3:4i], digit 0 least significant
- neg  output  1  result is negative (only when SIGNED=1)
- ovf  output  1  magnitude needs more than DIGITS digits
- blank  output  DIGITS  leading-zero mask; bit i = 1 means digit i is a leading zero

## Operation
- Internal digit count INT_DIG = (BIN_W*301)/1000 + 1. This always holds 2^BIN_W−1.
- State machine:
  - IDLE: if start=1, move to SHIFT. Latch mag = |din| (two's-complement negate if SIGNED and din[BIN_W-1]=1, else din). Latch sgn = SIGNED & din[BIN_W-1]. Clear the INT_DIG-digit accumulator. Load bit counter = BIN_W. Set busy=1.
  - SHIFT: each cycle, every accumulator digit ≥5 gets +3. Then {acc, mag} shifts left by 1 and the counter decrements. When the counter reaches 1 at this edge (i.e., after BIN_W shifts), move to FIN.
  - FIN: register the results, pulse done=1, clear busy, return to IDLE.
    - bcd = low DIGITS accumulator digits.
    - ovf = OR of the accumulator digits above DIGITS (0 if INT_DIG ≤ DIGITS).
    - neg = sgn.
    - blank: bit i = 1 iff digits i..DIGITS-1 are all zero and i ≠ 0. blank = 0 whenever ovf = 1.
- On overflow, bcd holds the value modulo 10^DIGITS.
- Most-negative input (−2^(BIN_W−1)): the magnitude fits in BIN_W unsigned bits and must convert correctly.
- With SIGNED=0, neg is always 0.
- start while busy, or in FIN: ignored, not queued.
- din is don't-care outside the accepting edge. The conversion uses the latched value.
- bcd, neg, ovf and blank hold their values between done pulses.
- Illegal parameter values: no behaviour is defined for them.

## Timing
- Reset (asynchronous, any time, including mid-conversion): state = IDLE, busy=0, done=0, bcd=0, neg=0, ovf=0, blank=0, internal registers cleared. An aborted conversion produces no done. The first start is accepted on the first rising edge with rst low.
- Accepting edge = E0. SHIFT edges are E1..EBIN_W. Results and done=1 appear after edge E(BIN_W+1). done is low again after E(BIN_W+2).
- Latency: BIN_W+1 clocks from the accepting edge to done.
- busy: 1 after E0 through edge E(BIN_W+1); 0 in the done cycle.
- With start held high, the next accept is at E(BIN_W+2). Throughput is one result per BIN_W+2 clocks; with defaults, one per 18 clocks.

## Test plan
- Defaults, din=16'd65535, 1-cycle start: done exactly 17 clocks after the accepting edge, for one cycle. Result: bcd=20'h65535, ovf=0, neg=0, blank=5'b00000.
- Defaults, din=0: bcd=20'h00000, blank=5'b11110, ovf=0. Then din=16'd42: bcd=20'h00042, blank=5'b11100.
- SIGNED=1:
  - din=16'h8000: bcd=20'h32768, neg=1, blank=0.
  - din=16'hFFFF: bcd=20'h00001, neg=1, blank=5'b11110.
  - din=16'h7FFF: bcd=20'h32767, neg=0.
- DIGITS=3, din=16'd1234: ovf=1, bcd=12'h234, blank=3'b000. Then din=16'd999: ovf=0, bcd=12'h999.
- Handshake:
  - start held high: done pulses every 18 clocks.
  - Extra start pulse and din change mid-conversion: no effect on the result or on timing.
  - Outputs stable between done pulses.
- Reset at the 8th SHIFT cycle of a din=12345 conversion: all outputs 0 asynchronously and no done pulse. A subsequent start with din=12345 gives bcd=20'h12345 after 17 clocks.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Optional two's-complement input, overflow flag and leading-zero blanking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; results held
// S_SHIFT | add-3 / shift one magnitude bit into the digit accumulator
// S_FIN   | register results, pulse done, return to idle
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  // Enough digits to hold 2^BIN_W-1; the accumulator is widened to DIGITS
  // when more output digits are requested than the value can ever need.
  localparam int INT_DIG = (BIN_W * 301) / 1000 + 1;
  localparam int ACC_DIG = (INT_DIG > DIGITS) ? INT_DIG : DIGITS;
  localparam int ACC_W   = 4 * ACC_DIG;
  localparam int CNT_W   = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    mag_q, mag_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sgn_q, sgn_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;

  logic                din_neg;
  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic                acc_ovf;
  logic [DIGITS-1:0]   blank_calc;
  logic                upper_zero;

  assign din_neg = (SIGNED != 0) && din[BIN_W-1];

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < ACC_DIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {acc_adj, mag_q} << 1;
  end

  // Overflow: any nonzero digit above the visible ones.
  generate
    if (ACC_DIG > DIGITS) begin : g_ovf
      assign acc_ovf = |acc_q[ACC_W-1:4*DIGITS];
    end else begin : g_no_ovf
      assign acc_ovf = 1'b0;
    end
  endgenerate

  // Leading-zero mask: digit i blanks when it and all digits above are zero;
  // digit 0 is always shown so a zero result reads "0".
  always_comb begin
    upper_zero = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (acc_q[4*i +: 4] == 4'd0);
      if (i != 0) blank_calc[i] = upper_zero;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          mag_d   = din_neg ? (~din + 1'b1) : din;
          sgn_d   = din_neg;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
        end
      end
      S_SHIFT: begin
        acc_d = shifted[ACC_W+BIN_W-1:BIN_W];
        mag_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        bcd_d   = acc_q[4*DIGITS-1:0];
        ovf_d   = acc_ovf;
        neg_d   = sgn_q;
        blank_d = acc_ovf ? '0 : blank_calc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      blank_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default, signed and 3-digit instances.
module tb_bin2bcd_seq;

  logic clk;
  logic rst;

  // index 0: defaults, 1: SIGNED=1, 2: DIGITS=3
  logic        start_v [3];
  logic [15:0] din_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [19:0] bcd_v   [3];
  logic        neg_v   [3];
  logic        ovf_v   [3];
  logic [4:0]  blank_v [3];

  logic [19:0] bcd_a, bcd_b;
  logic [11:0] bcd_c;
  logic [4:0]  blank_a, blank_b;
  logic [2:0]  blank_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        neg_a, neg_b, neg_c;
  logic        ovf_a, ovf_b, ovf_c;

  int n_chk  = 0;
  int n_pass = 0;

  bin2bcd_seq u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .din(din_v[0]),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .neg(neg_a), .ovf(ovf_a), .blank(blank_a)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .din(din_v[1]),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .neg(neg_b), .ovf(ovf_b), .blank(blank_b)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(3), .SIGNED(0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .din(din_v[2]),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .neg(neg_c), .ovf(ovf_c), .blank(blank_c)
  );

  assign busy_v[0] = busy_a;  assign busy_v[1] = busy_b;  assign busy_v[2] = busy_c;
  assign done_v[0] = done_a;  assign done_v[1] = done_b;  assign done_v[2] = done_c;
  assign bcd_v[0]  = bcd_a;   assign bcd_v[1]  = bcd_b;   assign bcd_v[2]  = {8'h00, bcd_c};
  assign neg_v[0]  = neg_a;   assign neg_v[1]  = neg_b;   assign neg_v[2]  = neg_c;
  assign ovf_v[0]  = ovf_a;   assign ovf_v[1]  = ovf_b;   assign ovf_v[2]  = ovf_c;
  assign blank_v[0] = blank_a; assign blank_v[1] = blank_b; assign blank_v[2] = {2'b00, blank_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One conversion on instance s; checks latency, busy and the done pulse.
  // With glitch set, a stray start and a din change land mid-conversion.
  task automatic run(input int s, input logic [15:0] v, input bit glitch);
    int lat;
    @(negedge clk);
    din_v[s]   = v;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(busy_v[s]), 32'd1);
    @(negedge clk);
    start_v[s] = 1'b0;
    din_v[s]   = ~v;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_v[s]) begin
        lat = k;
        break;
      end
      if (glitch && k == 5) begin
        start_v[s] = 1'b1;
        din_v[s]   = 16'h1111;
      end else if (glitch && k == 6) begin
        start_v[s] = 1'b0;
        din_v[s]   = 16'h2222;
      end
    end
    check("latency", 32'(lat), 32'd17);
    check("busy_in_done_cycle", 32'(busy_v[s]), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done_v[s]), 32'd0);
  endtask

  task automatic expect_res(input int s, input logic [19:0] b, input logic n,
                            input logic o, input logic [4:0] bl);
    check("bcd", 32'(bcd_v[s]), 32'(b));
    check("neg", 32'(neg_v[s]), 32'(n));
    check("ovf", 32'(ovf_v[s]), 32'(o));
    check("blank", 32'(blank_v[s]), 32'(bl));
  endtask

  initial begin
    int gap;
    int pulses;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      din_v[i]   = 16'h0;
    end
    rst = 1'b1;
    #12;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    expect_res(0, 20'h0, 1'b0, 1'b0, 5'b0);
    @(negedge clk);
    rst = 1'b0;

    // defaults
    run(0, 16'd65535, 1'b0);
    expect_res(0, 20'h65535, 1'b0, 1'b0, 5'b00000);
    run(0, 16'd0, 1'b0);
    expect_res(0, 20'h00000, 1'b0, 1'b0, 5'b11110);
    run(0, 16'd42, 1'b1);
    expect_res(0, 20'h00042, 1'b0, 1'b0, 5'b11100);
    repeat (10) @(posedge clk);
    #1;
    check("hold_done", 32'(done_a), 32'd0);
    expect_res(0, 20'h00042, 1'b0, 1'b0, 5'b11100);

    // signed
    run(1, 16'h8000, 1'b0);
    expect_res(1, 20'h32768, 1'b1, 1'b0, 5'b00000);
    run(1, 16'hFFFF, 1'b0);
    expect_res(1, 20'h00001, 1'b1, 1'b0, 5'b11110);
    run(1, 16'h7FFF, 1'b0);
    expect_res(1, 20'h32767, 1'b0, 1'b0, 5'b00000);

    // three visible digits
    run(2, 16'd1234, 1'b0);
    expect_res(2, 20'h00234, 1'b0, 1'b1, 5'b00000);
    run(2, 16'd999, 1'b0);
    expect_res(2, 20'h00999, 1'b0, 1'b0, 5'b00000);
    run(2, 16'd1000, 1'b0);
    expect_res(2, 20'h00000, 1'b0, 1'b1, 5'b00000);
    run(2, 16'd5, 1'b0);
    expect_res(2, 20'h00005, 1'b0, 1'b0, 5'b00110);

    // start held high: spacing between done pulses
    @(negedge clk);
    din_v[0]   = 16'd12;
    start_v[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_a) break;
    end
    check("held_first_done", 32'(done_a), 32'd1);
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        gap = k;
        break;
      end
    end
    check("held_period", 32'(gap), 32'd18);
    expect_res(0, 20'h00012, 1'b0, 1'b0, 5'b11100);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    #1;
    check("held_release_idle", 32'(busy_a), 32'd0);

    // asynchronous reset in the 8th shift cycle of 12345
    @(negedge clk);
    din_v[0]   = 16'd12345;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    expect_res(0, 20'h0, 1'b0, 1'b0, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done_a) pulses++;
    end
    check("arst_no_done", 32'(pulses), 32'd0);
    run(0, 16'd12345, 1'b0);
    expect_res(0, 20'h12345, 1'b0, 1'b0, 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
